// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared widths and fetch FSM state encoding
package if_fetch_unit_pkg;
  localparam int WORD_LEN = 32;
  localparam int INST_BYTES = 4;
  typedef enum logic [1:0] {
    FETCH_ST_IDLE  = 2'd0,
    FETCH_ST_REQ   = 2'd1,
    FETCH_ST_DRAIN = 2'd2
  } fetch_st_e;
endpackage

// File: rtl/if_fetch_unit_fifo.sv
// fetch_fifo: small flushable FIFO with a registered head that holds its last value when empty
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d, rd_adv;
  logic [WIDTH-1:0] head_q, head_d;
  logic do_push, do_pop;
  assign count = wr_q - rd_q;
  assign empty = count == '0;
  assign full = count[AW];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rd_adv = rd_q + (AW+1)'(do_pop);
  assign head = head_q;
  // Pointer update and the value the head register will show next cycle
  always_comb begin
    wr_d = flush ? '0 : wr_q + (AW+1)'(do_push);
    rd_d = flush ? '0 : rd_adv;
    head_d = (flush || wr_d == rd_d) ? head_q : (rd_adv == wr_q) ? wdata : mem_q[rd_adv[AW-1:0]];
  end
  // Pointer and head registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      head_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      head_q <= head_d;
    end
  end
  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch front end with single-outstanding imem handshake and decode FIFO
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter int W = WORD_LEN,
  parameter int DEPTH = 4,
  parameter logic [W-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         redirect,
  input  logic [W-1:0] redirect_addr,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         inst_valid,
  output logic [W-1:0] inst,
  output logic [W-1:0] inst_pc,
  input  logic         inst_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  fetch_st_e state_q, state_d;
  logic [W-1:0] fpc_q, fpc_d, req_addr_q, req_addr_d;
  logic [CW-1:0] count, count_after;
  logic [2*W-1:0] head;
  logic push, pop, full, empty, fits;
  assign pop = ~empty & inst_ready;
  assign push = imem_ack & ~redirect & ~full & (state_q == FETCH_ST_REQ);
  assign count_after = redirect ? '0 : count + CW'(push) - CW'(pop);
  assign fits = ~count_after[CW-1];
  assign imem_req = state_q != FETCH_ST_IDLE;
  assign imem_addr = req_addr_q;
  assign inst_valid = ~empty;
  assign {inst_pc, inst} = head;
  // Next fetch PC, FSM successor, and the address presented next cycle (old one kept while draining)
  always_comb begin
    fpc_d = redirect ? (redirect_addr & ~W'(INST_BYTES - 1)) : push ? fpc_q + W'(INST_BYTES) : fpc_q;
    state_d = ((state_q == FETCH_ST_IDLE) || imem_ack) ? (fits ? FETCH_ST_REQ : FETCH_ST_IDLE)
            : ((state_q == FETCH_ST_REQ) && redirect) ? FETCH_ST_DRAIN : state_q;
    req_addr_d = (state_d == FETCH_ST_DRAIN) ? req_addr_q : fpc_d;
  end
  // FSM, fetch PC and request address registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FETCH_ST_IDLE;
      fpc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      req_addr_q <= req_addr_d;
    end
  end
  fetch_fifo #(.WIDTH(2*W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect),
    .wdata({fpc_q, imem_rdata}),
    .full(full),
    .empty(empty),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed stimulus with a queue-based fetch model checked every cycle
module tb_if_fetch_unit;
  logic clk = 0, rst = 0, redirect = 0, imem_ack = 0, inst_ready = 1;
  logic [31:0] redirect_addr = '0, imem_rdata = '0;
  logic imem_req, inst_valid;
  logic [31:0] imem_addr, inst, inst_pc;
  int checks = 0, errors = 0, lat = 0, wcnt = 0;
  bit chk_en = 0;
  logic [63:0] m_q[$];
  bit m_busy = 0, m_stale = 0;
  logic [31:0] m_fpc = 0, m_addr = 0, m_hpc = 0, m_hinst = 0;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acknowledges a request after lat waiting cycles, data = addr ^ FFFF0000
  always @(negedge clk) begin
    if (!rst || !imem_req) begin
      imem_ack = 0;
      wcnt = 0;
    end else if (wcnt >= lat) begin
      imem_ack = 1;
      imem_rdata = imem_addr ^ 32'hFFFF_0000;
      wcnt = 0;
    end else begin
      imem_ack = 0;
      wcnt++;
    end
  end

  // Model: one outstanding request, a queue of fetched {pc, word}, flush on redirect
  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_busy = 0; m_stale = 0; m_fpc = 0; m_addr = 0; m_hpc = 0; m_hinst = 0;
    end else begin
      if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
      if (m_busy && imem_ack) begin
        if (!m_stale && !redirect) begin
          m_q.push_back({m_addr, imem_rdata});
          m_fpc = m_addr + 4;
        end
        m_busy = 0;
        m_stale = 0;
      end
      if (redirect) begin
        m_q.delete();
        m_fpc = redirect_addr & ~32'h3;
        m_stale = m_busy;
      end
      if (!m_busy && m_q.size() < 4) begin
        m_busy = 1;
        m_addr = m_fpc;
      end
      if (m_q.size() > 0) {m_hpc, m_hinst} = m_q[0];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_imem_req", 32'(imem_req), 32'(m_busy));
      if (m_busy) check("m_imem_addr", imem_addr, m_addr);
      check("m_inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
      check("m_inst", inst, m_hinst);
      check("m_inst_pc", inst_pc, m_hpc);
    end
  end

  task automatic do_reset(input int l, input logic rdy);
    @(negedge clk);
    rst = 0; lat = l; inst_ready = rdy; redirect = 0;
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  task automatic wait_addr(input string name, input logic [31:0] a);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = imem_req && imem_addr == a;
    end
    check(name, 32'(found), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1;
    check("rst_req", 32'(imem_req), 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", 32'(inst_valid), 0);
    check("rst_inst", inst, 0);
    check("rst_pc", inst_pc, 0);
    // streaming with zero-wait memory
    rst = 1;
    @(negedge clk);
    check("s1_req", 32'(imem_req), 1);
    check("s1_valid", 32'(inst_valid), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("s_valid", 32'(inst_valid), 1);
      check("s_pc", inst_pc, 32'(4 * i));
      check("s_inst", inst, 32'(4 * i) ^ 32'hFFFF_0000);
    end
    // backpressure
    do_reset(0, 0);
    repeat (10) @(negedge clk);
    check("bp_req", 32'(imem_req), 0);
    check("bp_pc", inst_pc, 0);
    inst_ready = 1;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      check("bp_drain_pc", inst_pc, 32'(4 * i));
      if (i == 1) check("bp_resume", imem_addr, 32'h10);
    end
    // slow memory, plus some patterned backpressure
    lat = 3;
    repeat (30) @(negedge clk);
    lat = 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      inst_ready = (i % 3) != 0;
    end
    inst_ready = 1;
    // redirect while a request to 0x8 is pending
    do_reset(3, 1);
    wait_addr("rw_find8", 32'h8);
    redirect = 1; redirect_addr = 32'h100;
    @(negedge clk);
    redirect = 0;
    check("rw_hold_req", 32'(imem_req), 1);
    check("rw_hold_addr", imem_addr, 32'h8);
    wait_addr("rw_new", 32'h100);
    begin
      bit found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
        @(negedge clk);
        found = inst_valid;
      end
      check("rw_first_pc", inst_pc, 32'h100);
      check("rw_first_inst", inst, 32'hFFFF_0100);
    end
    // redirect coincident with ack, unaligned target
    lat = 0;
    repeat (4) @(negedge clk);
    redirect = 1; redirect_addr = 32'h203;
    @(negedge clk);
    redirect = 0;
    check("ra_addr", imem_addr, 32'h200);
    check("ra_empty", 32'(inst_valid), 0);
    @(negedge clk);
    check("ra_pc", inst_pc, 32'h200);
    check("ra_inst", inst, 32'hFFFF_0200);
    // wrap at the top of the address space
    redirect = 1; redirect_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect = 0;
    check("wr_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wr_next", imem_addr, 32'h0);
    check("wr_pc", inst_pc, 32'hFFFF_FFFC);
    check("wr_inst", inst, 32'h0000_FFFC);
    // reset in the middle of a slow request
    lat = 3;
    repeat (3) @(negedge clk);
    check("mr_pending", 32'(imem_req), 1);
    rst = 0;
    @(negedge clk);
    check("mr_req", 32'(imem_req), 0);
    check("mr_valid", 32'(inst_valid), 0);
    check("mr_addr", imem_addr, 0);
    rst = 1;
    repeat (6) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
